// File: rtl/fp_accum_ctrl.sv
// fp_accum_ctrl: sequences the shared fp_adder to reduce a word stream into one sum.
// Define FP_ACC_ERR_STOP_EN to freeze the accumulator at the first adder exception.
module fp_accum_ctrl #(
  parameter int W = 39,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  output logic [W-1:0]     add_a,
  output logic [W-1:0]     add_b,
  input  logic [W-1:0]     add_sum,
  input  logic             add_khara,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic             out_err,
  input  logic             out_ready,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, LOAD, ADD, DONE} state_t;
  state_t state, state_n;
  logic [W-1:0] acc, acc_n, op_a, op_b;
  logic [CNT_W-1:0] remain;
  logic err;
`ifdef FP_ACC_ERR_STOP_EN
  assign acc_n = (err || add_khara) ? acc : add_sum;
`else
  assign acc_n = add_sum;
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = start ? (len == '0 ? DONE : LOAD) : IDLE;
      LOAD: state_n = in_valid ? ADD : LOAD;
      ADD:  state_n = remain == CNT_W'(1) ? DONE : LOAD;
      DONE: state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  assign in_ready  = state == LOAD;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  // result is only presented in DONE; zero otherwise
  assign out_data  = out_valid ? acc : '0;
  assign out_err   = out_valid & err;
  assign add_a     = op_a;
  assign add_b     = op_b;
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      acc    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      remain <= '0;
      err    <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        acc    <= '0;
        err    <= 1'b0;
        remain <= len;
      end
      if (state == LOAD && in_valid) begin
        op_a <= acc;
        op_b <= in_data;
      end
      if (state == ADD) begin
        acc    <= acc_n;
        err    <= err | add_khara;
        remain <= remain - CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_fp_accum_ctrl.sv
// tb_fp_accum_ctrl: directed runs against an integer adder stub, checked by a result scoreboard.
module tb_fp_accum_ctrl;
  logic clk = 1'b0;
  logic reset, start, in_valid, in_ready, add_khara, out_valid, out_err, out_ready, busy;
  logic [15:0] len;
  logic [38:0] in_data, add_a, add_b, add_sum, out_data;
  logic [39:0] sb[$];
  int total = 0, pass = 0, cyc = 0, consumed = 0, rdy_cnt = 0;

  fp_accum_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .add_a(add_a), .add_b(add_b),
    .add_sum(add_sum), .add_khara(add_khara), .out_valid(out_valid),
    .out_data(out_data), .out_err(out_err), .out_ready(out_ready), .busy(busy)
  );

  assign {add_khara, add_sum} = {1'b0, add_a} + {1'b0, add_b};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail(input string name);
    total++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  always @(negedge clk) begin
    if (in_ready) rdy_cnt++;
    if (in_ready && in_valid) consumed++;
    if (out_valid) begin
      if (sb.size() == 0) fail("stale_out_valid");
      else begin
        chk("out_data", 64'(out_data), 64'(sb[0][38:0]));
        chk("out_err", 64'(out_err), 64'(sb[0][39]));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic run(input int n, input logic [38:0] e0, e1, e2, e3, input int gap,
                     input int rdly, input logic [38:0] exp_d, input logic exp_e,
                     input int exp_lat, input bit poke);
    logic [38:0] el[4];
    int t0, k;
    el[0] = e0; el[1] = e1; el[2] = e2; el[3] = e3;
    sb.push_back({exp_e, exp_d});
    @(posedge clk); #1;
    consumed = 0; rdy_cnt = 0;
    start = 1'b1; len = 16'(n); t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gap > 0) begin
        in_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
      in_valid = 1'b1; in_data = el[i];
      k = 0;
      @(negedge clk);
      while (!in_ready && k < 50) begin @(negedge clk); k++; end
      if (k >= 50) fail("in_ready_wait");
      @(posedge clk); #1;
      if (poke && i == 0) begin
        start = 1'b1; len = 16'd7;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    in_valid = 1'b0;
    k = 0;
    @(negedge clk);
    while (!out_valid && k < 100) begin @(negedge clk); k++; end
    if (k >= 100) fail("out_valid_wait");
    if (exp_lat >= 0) chk("latency", 64'(cyc - t0), 64'(exp_lat));
    chk("busy_done", 64'(busy), 64'd1);
    repeat (rdly) @(posedge clk);
    #1;
    out_ready = 1'b1;
    if (poke) begin start = 1'b1; len = 16'd7; end
    @(negedge clk);
    @(posedge clk); #1;
    out_ready = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("busy_after", 64'(busy), 64'd0);
    chk("consumed", 64'(consumed), 64'(n));
    chk("sb_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    chk("rst_add_a", 64'(add_a), 64'd0);
    chk("rst_add_b", 64'(add_b), 64'd0);
    run(3, 39'd5, 39'd7, 39'd9, 39'd0, 0, 1, 39'd21, 1'b0, 7, 1'b0);
    chk("rdy_alt", 64'(rdy_cnt), 64'd3);
    run(0, 39'd0, 39'd0, 39'd0, 39'd0, 0, 1, 39'd0, 1'b0, 1, 1'b0);
    chk("rdy_len0", 64'(rdy_cnt), 64'd0);
`ifdef FP_ACC_ERR_STOP_EN
    run(2, 39'h7F_FFFF_FFFF, 39'd2, 39'd0, 39'd0, 0, 1, 39'h7F_FFFF_FFFF, 1'b1, 5, 1'b0);
`else
    run(2, 39'h7F_FFFF_FFFF, 39'd2, 39'd0, 39'd0, 0, 1, 39'd1, 1'b1, 5, 1'b0);
`endif
    run(2, 39'd100, 39'd23, 39'd0, 39'd0, 4, 3, 39'd123, 1'b0, -1, 1'b0);
    run(3, 39'd1, 39'd2, 39'd3, 39'd0, 0, 2, 39'd6, 1'b0, 7, 1'b1);
    // abort a 4-element run during the ADD of element 2
    @(posedge clk); #1;
    start = 1'b1; len = 16'd4;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = 39'd10;
    @(posedge clk); #1;
    in_data = 39'd20;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1; in_data = 39'd30;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_add_a", 64'(add_a), 64'd0);
    chk("abort_add_b", 64'(add_b), 64'd0);
    run(1, 39'd3, 39'd0, 39'd0, 39'd0, 0, 1, 39'd3, 1'b0, 3, 1'b0);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/fp_accum_ctrl.md
# fp_accum_ctrl

Sequencing controller that drives the shared combinational `fp_adder` to reduce a stream of 39-bit floating-point words into one sum. In the vector-norm processor it sits between the squared-element stream and the root stage. It accepts a run length on `start`, pulls elements over a valid/ready handshake and presents each operand pair to the adder. It folds every adder result into a running accumulator, then holds the final sum and a sticky error flag until the consumer takes them.

## Interface
- `W`, 39: float word width; bits [38:30] are the 9-bit exponent, bits [29:0] the 30-bit mantissa; all-zero word = 0.0.
- `CNT_W`, 16: width of the run-length counter.

- `clk`  in  1  sole clock; every register updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a run; sampled only in IDLE.
- `len`  in  CNT_W  number of elements in the run; sampled with `start`.
- `in_valid`  in  1  `in_data` is valid.
- `in_data`  in  W  element to accumulate.
- `in_ready`  out  1  controller accepts `in_data` this cycle.
- `add_a`  out  W  adder operand A (accumulator); drives `fp_adder.a_original`.
- `add_b`  out  W  adder operand B (element); drives `fp_adder.b_original`.
- `add_sum`  in  W  adder result; from `fp_adder.sum`.
- `add_khara`  in  1  adder exception flag; from `fp_adder.khara`.
- `out_valid`  out  1  `out_data` and `out_err` are valid.
- `out_data`  out  W  final accumulated sum.
- `out_err`  out  1  sticky: `add_khara` was seen during the run.
- `out_ready`  in  1  consumer accepts the result.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states are IDLE, LOAD, ADD and DONE.
- IDLE:
  - `in_ready`=0.
  - On `start`: `acc`←0, `err`←0, `remain`←`len`.
  - Go to DONE if `len`==0, else go to LOAD.
- LOAD:
  - `in_ready`=1.
  - On `in_valid`: `op_b`←`in_data`, `op_a`←`acc`, go to ADD.
  - Otherwise stay in LOAD.
- ADD:
  - `in_ready`=0.
  - The adder is combinational on the registered `op_a`/`op_b`.
  - `acc`←`add_sum`; `err`←`err | add_khara`; `remain`←`remain`−1.
  - Go to DONE if `remain`==1, else go to LOAD.
- DONE:
  - `out_valid`=1, `out_data`=`acc`, `out_err`=`err`.
  - On `out_ready`, go to IDLE.
- `add_a`=`op_a` and `add_b`=`op_b` at all times, so adder inputs only change on LOAD→ADD.
- `start` outside IDLE is ignored; `len` is not re-sampled mid-run.
- `in_valid` outside LOAD is ignored and not consumed.
- The controller never interprets the float format. It only moves words; all arithmetic is in `fp_adder`.
- Counter arithmetic is unsigned CNT_W. `len`=2^CNT_W−1 is legal. There is no wrap, because `remain` is never decremented at 0.

## Timing
- Reset values: state IDLE; `acc`, `op_a`, `op_b`, `remain`, `err` all 0.
- Output values in IDLE / after reset: `in_ready`, `out_valid`, `out_err`, `busy` = 0; `out_data`, `add_a`, `add_b` = 0.
- Reset mid-run aborts immediately. The partial sum is discarded and no `out_valid` is produced. An element presented in the reset cycle is not consumed.
- Throughput is one element per 2 cycles.
- Latency with `in_valid` held high: `start` at cycle T gives LOAD at T+1, and `out_valid` first high at T+2N+1.
  - `len`=0: `out_valid` at T+1, `out_data`=0, `out_err`=0.
- `out_valid`, `out_data` and `out_err` stay stable until the `out_ready` cycle. `busy` falls in the cycle after the handshake.
- `start` in the same cycle as the DONE handshake is ignored; the state is not yet IDLE.
- `in_valid` stalls in LOAD extend the run with no state change.

## Configuration
- `FP_ACC_ERR_STOP_EN` defined:
  - The first ADD with `add_khara`=1 sets `err` and freezes `acc` at its pre-add value.
  - The controller still consumes all remaining `len` elements, without updating `acc`.
  - `out_data` = the last good sum.
- `FP_ACC_ERR_STOP_EN` undefined:
  - `acc` always takes `add_sum`, including exception cycles.
  - `err` is sticky only.

## Test plan
The bench uses a behavioural adder stub: `add_sum` = (`add_a`+`add_b`) mod 2^39, and `add_khara` = carry out of bit 38.

- Reset, then `start`, `len`=3, inputs 5, 7, 9 with `in_valid` held high → `out_valid` at T+7, `out_data`=21, `out_err`=0. `in_ready` pulses on alternate cycles.
- `start`, `len`=0 → `out_valid` at T+1, `out_data`=0, and `in_ready` never asserts.
- `len`=2, inputs 0x7F_FFFF_FFFF and 2 (stub carry) → `out_err`=1.
  - `FP_ACC_ERR_STOP_EN` defined: `out_data`=0x7F_FFFF_FFFF.
  - Undefined: `out_data`=1.
- `len`=2, `in_valid` low for 4 cycles before each element, `out_ready` low for 3 cycles in DONE → sum correct; `out_data`/`out_err` stable while waiting; `busy` falls the cycle after the handshake.
- `start` pulsed during ADD and during DONE with a different `len` → ignored; the original run completes with the original count.
- `reset` asserted in the ADD of element 2 of 4, then a fresh run `len`=1 with input 3 → no stale `out_valid`; the new result is 3.
